fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Drains cmd_len words from a FIFO with one-cycle read latency into a
// 2-entry output buffer presented as a valid/ready stream.
module fifo_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [LW-1:0]    cmd_len,
  output logic             cmd_ready,
  input  logic             empty,
  output logic             pop,
  input  logic [WIDTH-1:0] rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [LW-1:0]    r_remaining;
  logic             r_inflight;
  logic             r_inflightLast;
  logic [1:0]       r_bufCnt;
  logic [WIDTH-1:0] r_bufData [2];
  logic             r_bufLast [2];
  logic             r_done;
  logic             w_accept;
  logic             w_xfer;
  logic [2:0]       w_occupancy;

  always_comb begin
    w_accept    = cmd_valid && (r_state == IDLE);
    w_xfer      = (r_bufCnt != 2'd0) && out_ready;
    // Words that will still be held after this edge if nothing new arrives.
    w_occupancy = {1'b0, r_bufCnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && (cmd_len != '0)) begin
          w_nextState = READ;
        end
      end
      READ: begin
        if (pop && (r_remaining == LW'(1))) begin
          w_nextState = FLUSH;
        end
      end
      FLUSH: begin
        if (w_xfer && r_bufLast[0]) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == IDLE);
    busy      = (r_state != IDLE);
    pop       = rstn && (r_state == READ) && (r_remaining != '0) && !empty &&
                (w_occupancy < 3'd2);
    out_valid = (r_bufCnt != 2'd0);
    out_data  = r_bufData[0];
    out_last  = r_bufLast[0] && (r_bufCnt != 2'd0);
    done      = r_done;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_remaining    <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_bufCnt       <= 2'd0;
      r_bufData[0]   <= '0;
      r_bufData[1]   <= '0;
      r_bufLast[0]   <= 1'b0;
      r_bufLast[1]   <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= (w_accept && (cmd_len == '0)) ||
                ((r_state == FLUSH) && w_xfer && r_bufLast[0]);

      if (w_accept) begin
        r_remaining <= cmd_len;
      end else if (pop) begin
        r_remaining <= r_remaining - LW'(1);
      end

      r_inflight     <= pop;
      r_inflightLast <= pop && (r_remaining == LW'(1));

      // Entry 0 is always the head; a capture lands behind whatever survives.
      case ({r_inflight, w_xfer})
        2'b10: begin
          r_bufData[r_bufCnt[0]] <= rd;
          r_bufLast[r_bufCnt[0]] <= r_inflightLast;
          r_bufCnt               <= r_bufCnt + 2'd1;
        end
        2'b01: begin
          r_bufData[0] <= r_bufData[1];
          r_bufLast[0] <= r_bufLast[1];
          r_bufCnt     <= r_bufCnt - 2'd1;
        end
        2'b11: begin
          if (r_bufCnt == 2'd1) begin
            r_bufData[0] <= rd;
            r_bufLast[0] <= r_inflightLast;
          end else begin
            r_bufData[0] <= r_bufData[1];
            r_bufLast[0] <= r_bufLast[1];
            r_bufData[1] <= rd;
            r_bufLast[1] <= r_inflightLast;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized self-checking bench: a pointer-based FIFO model feeds the DUT and
// every command must return the next cmd_len words in push order.
`timescale 1ns/1ps
module tb_fifo_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LW-1:0]    cmd_len   = '0;
  logic             cmd_ready;
  logic             empty;
  logic             pop;
  logic [WIDTH-1:0] rd        = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             done;
  logic             busy;

  always #5 clk = ~clk;

  fifo_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .empty     (empty),
    .pop       (pop),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  // FIFO model: the word popped at an edge appears on rd right after it.
  logic [WIDTH-1:0] mem [0:1023];
  int  wptr = 0;
  int  rptr = 0;
  bit  popSeen = 1'b0;
  assign empty = (rptr == wptr);

  always @(posedge clk) begin
    if (popSeen && (rptr != wptr)) begin
      rd   <= mem[rptr];
      rptr <= rptr + 1;
    end
  end

  int readyMode  = 0;
  int readyPhase = 0;
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: out_ready = 1'b1;
      1: begin
        out_ready  = ((readyPhase % 3) == 0);
        readyPhase = readyPhase + 1;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor samples on the falling edge what the next rising edge will see.
  int cyc = 0, popCount = 0, popWhileEmpty = 0, obsN = 0, doneCount = 0;
  int acceptCount = 0, stableErr = 0, busyReadyErr = 0;
  int outstanding = 0, maxOutstanding = 0;
  logic [WIDTH-1:0] obsData [0:1023];
  bit               obsLast [0:1023];
  int               obsCyc  [0:1023];
  int               doneLog [0:255];
  int               acceptLog [0:255];
  bit               prevStall = 1'b0;
  logic [WIDTH-1:0] prevData  = '0;
  logic             prevLast  = 1'b0;

  always @(negedge clk) begin
    cyc     = cyc + 1;
    popSeen = (pop === 1'b1);
    if (pop === 1'b1) begin
      popCount = popCount + 1;
      if (empty) popWhileEmpty = popWhileEmpty + 1;
    end
    if (prevStall && (out_valid !== 1'b1 || out_data !== prevData || out_last !== prevLast))
      stableErr = stableErr + 1;
    prevStall = rstn && (out_valid === 1'b1) && !out_ready;
    prevData  = out_data;
    prevLast  = out_last;
    if (rstn && out_valid === 1'b1 && out_ready) begin
      obsData[obsN] = out_data;
      obsLast[obsN] = (out_last === 1'b1);
      obsCyc[obsN]  = cyc;
      obsN = obsN + 1;
    end
    if (done === 1'b1) begin
      doneLog[doneCount] = cyc;
      doneCount = doneCount + 1;
    end
    if (rstn && cmd_valid && cmd_ready === 1'b1) begin
      acceptLog[acceptCount] = cyc;
      acceptCount = acceptCount + 1;
    end
    if (busy === 1'b1 && cmd_ready === 1'b1) busyReadyErr = busyReadyErr + 1;
    if (!rstn) outstanding = 0;
    else outstanding = outstanding + int'(pop === 1'b1) - int'(out_valid === 1'b1 && out_ready);
    if (outstanding > maxOutstanding) maxOutstanding = outstanding;
  end

  int errors = 0;
  int checks = 0;
  int expIdx = 0;

  task automatic pushWord(input logic [WIDTH-1:0] v);
    mem[wptr] = v;
    wptr = wptr + 1;
  endtask

  task automatic issueCmd(input int len);
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; readyMode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pop !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop: got %b want 0", pop); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_burst();
    int b = obsN, p = popCount, d = doneCount, a = acceptCount;
    bit ok;
    for (int k = 0; k < 16; k++) pushWord(WIDTH'(k));
    readyMode = 0;
    @(posedge clk); #1;
    issueCmd(16);
    waitDone(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL burst_done_seen: got 0 want 1"); end
    checks++; if (obsN - b != 16) begin errors++; $display("[TB] FAIL burst_count: got %0d want 16", obsN - b); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obsData[b+k] !== WIDTH'(k) || obsLast[b+k] !== (k == 15)) begin
        errors++; $display("[TB] FAIL burst_word%0d: got %h/%b want %h/%b", k, obsData[b+k], obsLast[b+k], k, (k == 15));
      end
    end
    checks++; if (obsCyc[b] != acceptLog[a] + 3) begin errors++; $display("[TB] FAIL burst_latency: got %0d want %0d", obsCyc[b] - acceptLog[a], 3); end
    checks++; if (obsCyc[b+15] != obsCyc[b] + 15) begin errors++; $display("[TB] FAIL burst_throughput: got span %0d want 15", obsCyc[b+15] - obsCyc[b]); end
    checks++; if (doneLog[d] != obsCyc[b+15] + 1) begin errors++; $display("[TB] FAIL burst_done_timing: got %0d want %0d", doneLog[d], obsCyc[b+15] + 1); end
    checks++; if (popCount - p != 16) begin errors++; $display("[TB] FAIL burst_pops: got %0d want 16", popCount - p); end
    expIdx += 16;
  endtask

  task automatic test_backpressure();
    int b = obsN, p = popCount, s = stableErr;
    bit ok;
    for (int k = 0; k < 4; k++) pushWord(WIDTH'($urandom));
    readyMode = 1;
    issueCmd(4);
    waitDone(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_seen: got 0 want 1"); end
    checks++; if (obsN - b != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d want 4", obsN - b); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obsData[b+k] !== mem[expIdx+k] || obsLast[b+k] !== (k == 3)) begin
        errors++; $display("[TB] FAIL bp_word%0d: got %h/%b want %h/%b", k, obsData[b+k], obsLast[b+k], mem[expIdx+k], (k == 3));
      end
    end
    checks++; if (stableErr != s) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable stalls want 0", stableErr - s); end
    checks++; if (maxOutstanding > 2) begin errors++; $display("[TB] FAIL bp_buffered: got %0d want <=2", maxOutstanding); end
    checks++; if (popCount - p != 4) begin errors++; $display("[TB] FAIL bp_pops: got %0d want 4", popCount - p); end
    expIdx += 4;
    readyMode = 0;
  endtask

  task automatic test_empty_stall();
    int b = obsN, p = popCount, d = doneCount, pe = popWhileEmpty;
    bit ok;
    for (int k = 0; k < 2; k++) pushWord(WIDTH'($urandom));
    readyMode = 0;
    issueCmd(5);
    repeat (9) @(posedge clk);
    #1;
    checks++; if (popCount - p != 2) begin errors++; $display("[TB] FAIL stall_pops_early: got %0d want 2", popCount - p); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy: got %b want 1", busy); end
    for (int k = 0; k < 3; k++) pushWord(WIDTH'($urandom));
    waitDone(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_done_seen: got 0 want 1"); end
    checks++; if (obsN - b != 5) begin errors++; $display("[TB] FAIL stall_count: got %0d want 5", obsN - b); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obsData[b+k] !== mem[expIdx+k] || obsLast[b+k] !== (k == 4)) begin
        errors++; $display("[TB] FAIL stall_word%0d: got %h/%b want %h/%b", k, obsData[b+k], obsLast[b+k], mem[expIdx+k], (k == 4));
      end
    end
    checks++; if (popWhileEmpty != pe) begin errors++; $display("[TB] FAIL stall_pop_empty: got %0d want 0", popWhileEmpty - pe); end
    checks++; if (doneLog[d] != obsCyc[b+4] + 1) begin errors++; $display("[TB] FAIL stall_done_timing: got %0d want %0d", doneLog[d], obsCyc[b+4] + 1); end
    checks++; if (popCount - p != 5) begin errors++; $display("[TB] FAIL stall_pops: got %0d want 5", popCount - p); end
    expIdx += 5;
  endtask

  task automatic test_zero_len();
    int p = popCount, d = doneCount, a = acceptCount;
    pushWord(WIDTH'($urandom));
    issueCmd(0);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b want 1", done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse: got %b want 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (popCount != p) begin errors++; $display("[TB] FAIL zero_pops: got %0d want 0", popCount - p); end
    checks++; if (doneCount - d != 1 || doneLog[d] != acceptLog[a] + 1) begin
      errors++; $display("[TB] FAIL zero_done_count: got %0d at +%0d want 1 at +1", doneCount - d, doneLog[d] - acceptLog[a]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cmd_hold();
    int b = obsN, d = doneCount, a = acceptCount, br = busyReadyErr;
    bit ok;
    for (int k = 0; k < 5; k++) pushWord(WIDTH'($urandom));
    readyMode = 0;
    cmd_valid = 1'b1;
    cmd_len   = LW'(3);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (acceptCount - a >= 2) break;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waitDone(200, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_done_seen: got 0 want 1"); end
    checks++; if (acceptCount - a != 2) begin errors++; $display("[TB] FAIL hold_accepts: got %0d want 2", acceptCount - a); end
    checks++; if (acceptLog[a+1] != doneLog[d]) begin errors++; $display("[TB] FAIL hold_second_accept: got cycle %0d want %0d", acceptLog[a+1], doneLog[d]); end
    checks++; if (doneCount - d != 2) begin errors++; $display("[TB] FAIL hold_done_count: got %0d want 2", doneCount - d); end
    checks++; if (busyReadyErr != br) begin errors++; $display("[TB] FAIL hold_ready_busy: got %0d want 0", busyReadyErr - br); end
    checks++; if (obsN - b != 6) begin errors++; $display("[TB] FAIL hold_count: got %0d want 6", obsN - b); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obsData[b+k] !== mem[expIdx+k] || obsLast[b+k] !== (k == 2 || k == 5)) begin
        errors++; $display("[TB] FAIL hold_word%0d: got %h/%b want %h/%b", k, obsData[b+k], obsLast[b+k], mem[expIdx+k], (k == 2 || k == 5));
      end
    end
    expIdx += 6;
  endtask

  task automatic test_reset_mid();
    int b = obsN;
    bit ok;
    for (int k = 0; k < 8; k++) pushWord(WIDTH'($urandom));
    readyMode = 0;
    issueCmd(8);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (obsN - b >= 3) break;
    end
    readyMode = 3;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (pop !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pop_in_reset: got %b want 0", pop); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (pop !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rmid_outputs: got pop=%b ov=%b od=%h ol=%b dn=%b bz=%b cr=%b want 0 0 00 0 0 0 1", pop, out_valid, out_data, out_last, done, busy, cmd_ready);
    end
    checks++; if (obsN - b != 3) begin errors++; $display("[TB] FAIL rmid_delivered: got %0d want 3", obsN - b); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obsData[b+k] !== mem[expIdx+k]) begin errors++; $display("[TB] FAIL rmid_word%0d: got %h want %h", k, obsData[b+k], mem[expIdx+k]); end
    end
    expIdx = rptr;
    b = obsN;
    readyMode = 0;
    @(posedge clk); #1;
    issueCmd(2);
    waitDone(100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_done_seen: got 0 want 1"); end
    checks++; if (obsN - b != 2) begin errors++; $display("[TB] FAIL rmid_new_count: got %0d want 2", obsN - b); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsData[b+k] !== mem[expIdx+k] || obsLast[b+k] !== (k == 1)) begin
        errors++; $display("[TB] FAIL rmid_new_word%0d: got %h/%b want %h/%b", k, obsData[b+k], obsLast[b+k], mem[expIdx+k], (k == 1));
      end
    end
    expIdx += 2;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len, pre, b, p, d, pe, s;
      bit ok;
      len = $urandom_range(1, 16);
      pre = $urandom_range(0, len);
      b = obsN; p = popCount; d = doneCount; pe = popWhileEmpty; s = stableErr;
      readyMode = $urandom_range(0, 2);
      for (int k = 0; k < pre; k++) pushWord(WIDTH'($urandom));
      issueCmd(len);
      for (int k = pre; k < len; k++) begin
        int gap;
        gap = $urandom_range(0, 3);
        @(posedge clk); #1;
        pushWord(WIDTH'($urandom));
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
      waitDone(400, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_done_seen: got 0 want 1", it); end
      checks++; if (obsN - b != len) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", it, obsN - b, len); end
      for (int k = 0; k < len; k++) begin
        checks++;
        if (obsData[b+k] !== mem[expIdx+k] || obsLast[b+k] !== (k == len - 1)) begin
          errors++; $display("[TB] FAIL rand%0d_word%0d: got %h/%b want %h/%b", it, k, obsData[b+k], obsLast[b+k], mem[expIdx+k], (k == len - 1));
        end
      end
      checks++; if (doneLog[d] != obsCyc[b+len-1] + 1) begin errors++; $display("[TB] FAIL rand%0d_done_timing: got %0d want %0d", it, doneLog[d], obsCyc[b+len-1] + 1); end
      checks++; if (popCount - p != len) begin errors++; $display("[TB] FAIL rand%0d_pops: got %0d want %0d", it, popCount - p, len); end
      checks++; if (popWhileEmpty != pe || stableErr != s) begin
        errors++; $display("[TB] FAIL rand%0d_protocol: got pop_empty=%0d unstable=%0d want 0 0", it, popWhileEmpty - pe, stableErr - s);
      end
      expIdx += len;
    end
    checks++; if (maxOutstanding > 2) begin errors++; $display("[TB] FAIL rand_buffered: got %0d want <=2", maxOutstanding); end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_cmd_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
